// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic-light sequencer: state codes, timer
// field bounds and the internal FSM encoding.
package tlc_pkg;

  localparam logic [1:0] ST_OFF    = 2'b00;
  localparam logic [1:0] ST_RED    = 2'b01;
  localparam logic [1:0] ST_GREEN  = 2'b10;
  localparam logic [1:0] ST_YELLOW = 2'b11;

  localparam int G2Y_HI = 31;
  localparam int G2Y_LO = 20;
  localparam int R2G_HI = 19;
  localparam int R2G_LO = 8;
  localparam int Y2R_HI = 7;
  localparam int Y2R_LO = 0;

  localparam int CNT_W = 12;

  // Blink modes get their own FSM states so that normal RED and blinking RED,
  // which share a status code, can still be told apart.
  typedef enum logic [2:0] {
    FSM_OFF,
    FSM_RED,
    FSM_GREEN,
    FSM_YELLOW,
    FSM_BLINK_R,
    FSM_BLINK_Y
  } fsm_e;

  function automatic logic [1:0] state_code(input fsm_e s);
    case (s)
      FSM_RED, FSM_BLINK_R:    state_code = ST_RED;
      FSM_GREEN:               state_code = ST_GREEN;
      FSM_YELLOW, FSM_BLINK_Y: state_code = ST_YELLOW;
      default:                 state_code = ST_OFF;
    endcase
  endfunction

endpackage

// File: rtl/tlc_tick_gen.sv
// Timer prescaler: pulses tick once every TICK_DIV clocks; clr holds the
// divider at zero. With TICK_DIV=1 tick is permanently high.
module tlc_tick_gen #(
  parameter int TICK_DIV = 1
) (
  input  logic pclk,
  input  logic presetn,
  input  logic clr,
  output logic tick
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  logic [DW-1:0] div_cnt_reg;
  logic [DW-1:0] div_cnt_next;

  assign tick = (div_cnt_reg == DIV_LAST);

  always_comb begin
    div_cnt_next = div_cnt_reg + 1'b1;
    if (clr || tick) begin
      div_cnt_next = '0;
    end
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_next;
    end
  end

endmodule

// File: rtl/traffic_light_fsm.sv
// Red/green/yellow sequencer driven by the ctl/timer registers, with red and
// yellow blink modes, registered lamp outputs and a state-change pulse.
module traffic_light_fsm
  import tlc_pkg::*;
#(
  parameter int SIZE      = 32,
  parameter int TICK_DIV  = 1,
  parameter int BLINK_CYC = 4
) (
  input  logic            pclk,
  input  logic            presetn,
  input  logic            mod_en,
  input  logic            blink_yellow,
  input  logic            blink_red,
  input  logic            profile,
  input  logic [SIZE-1:0] timer_0,
  input  logic [SIZE-1:0] timer_1,
  output logic [1:0]      state,
  output logic            red,
  output logic            yellow,
  output logic            green,
  output logic            state_chg
);

  localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);

  fsm_e             fsm_reg, fsm_next;
  fsm_e             blink_tgt;
  logic [CNT_W-1:0] phase_cnt_reg, phase_cnt_next;
  logic [BW-1:0]    blink_cnt_reg, blink_cnt_next;
  logic             blink_on_reg, blink_on_next;
  logic [1:0]       state_reg;
  logic             state_chg_reg;
  logic [2:0]       lamp_reg, lamp_next;   // {red, yellow, green}
  logic             tick;

  logic [SIZE-1:0]  sel_timer;
  logic [CNT_W-1:0] g2y, r2g, y2r;

  assign sel_timer = profile ? timer_1 : timer_0;
  assign g2y       = sel_timer[G2Y_HI:G2Y_LO];
  assign r2g       = sel_timer[R2G_HI:R2G_LO];
  assign y2r       = CNT_W'(sel_timer[Y2R_HI:Y2R_LO]);

  tlc_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .pclk    (pclk),
    .presetn (presetn),
    .clr     (fsm_reg == FSM_OFF),
    .tick    (tick)
  );

  always_comb begin
    fsm_next       = fsm_reg;
    phase_cnt_next = phase_cnt_reg;
    blink_cnt_next = blink_cnt_reg;
    blink_on_next  = blink_on_reg;
    blink_tgt      = blink_red ? FSM_BLINK_R : FSM_BLINK_Y;

    if (!mod_en) begin
      fsm_next       = FSM_OFF;
      phase_cnt_next = '0;
      blink_cnt_next = '0;
      blink_on_next  = 1'b0;
    end else if (blink_red || blink_yellow) begin
      phase_cnt_next = '0;
      if (fsm_reg != blink_tgt) begin
        fsm_next       = blink_tgt;
        blink_cnt_next = '0;
        blink_on_next  = 1'b1;
      end else if (tick) begin
        if (blink_cnt_reg == BLINK_LAST) begin
          blink_cnt_next = '0;
          blink_on_next  = !blink_on_reg;
        end else begin
          blink_cnt_next = blink_cnt_reg + 1'b1;
        end
      end
    end else begin
      blink_cnt_next = '0;
      blink_on_next  = 1'b0;
      // Timer fields are sampled only on the edge that enters a phase.
      case (fsm_reg)
        FSM_RED, FSM_GREEN, FSM_YELLOW: begin
          if (tick) begin
            if (phase_cnt_reg == '0) begin
              case (fsm_reg)
                FSM_RED: begin
                  fsm_next       = FSM_GREEN;
                  phase_cnt_next = g2y;
                end
                FSM_GREEN: begin
                  fsm_next       = FSM_YELLOW;
                  phase_cnt_next = y2r;
                end
                default: begin
                  fsm_next       = FSM_RED;
                  phase_cnt_next = r2g;
                end
              endcase
            end else begin
              phase_cnt_next = phase_cnt_reg - 1'b1;
            end
          end
        end
        default: begin
          fsm_next       = FSM_RED;
          phase_cnt_next = r2g;
        end
      endcase
    end
  end

  always_comb begin
    lamp_next = 3'b000;
    case (fsm_next)
      FSM_RED:     lamp_next[2] = 1'b1;
      FSM_GREEN:   lamp_next[0] = 1'b1;
      FSM_YELLOW:  lamp_next[1] = 1'b1;
      FSM_BLINK_R: lamp_next[2] = blink_on_next;
      FSM_BLINK_Y: lamp_next[1] = blink_on_next;
      default:     lamp_next    = 3'b000;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      fsm_reg       <= FSM_OFF;
      phase_cnt_reg <= '0;
      blink_cnt_reg <= '0;
      blink_on_reg  <= 1'b0;
      state_reg     <= ST_OFF;
      state_chg_reg <= 1'b0;
    end else begin
      fsm_reg       <= fsm_next;
      phase_cnt_reg <= phase_cnt_next;
      blink_cnt_reg <= blink_cnt_next;
      blink_on_reg  <= blink_on_next;
      state_reg     <= state_code(fsm_next);
      state_chg_reg <= (state_code(fsm_next) != state_reg);
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_lamp
    always_ff @(posedge pclk) begin
      if (!presetn) begin
        lamp_reg[gi] <= 1'b0;
      end else begin
        lamp_reg[gi] <= lamp_next[gi];
      end
    end
  end

  assign state     = state_reg;
  assign red       = lamp_reg[2];
  assign yellow    = lamp_reg[1];
  assign green     = lamp_reg[0];
  assign state_chg = state_chg_reg;

endmodule
